// File: rtl/alu_4bit.sv
// alu_4bit: 4-bit ALU with 16 operations selected by m.
// The result and signed-overflow flag are registered, so both reflect the
// operands sampled on the previous rising edge of clk.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-high reset, clears r and overflow
//   a         in   4  operand A; sole source for shift/rotate ops
//   b         in   4  operand B; unused for m >= 8
//   cin       in   1  carry/borrow in; used only by ADD (m=0) and SUB (m=1)
//   m         in   4  operation select
//   r         out  4  registered result
//   overflow  out  1  registered signed-overflow flag
//
// Op map:
//   0 ADD   1 SUB   2 CMP(unsigned)   3 AND   4 OR   5 XOR   6 NOR   7 XNOR
//   8 SLL0  9 SLL1  10 SRL0  11 SRL1  12 SLA  13 SRA  14 ROL  15 ROR
module alu_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic [3:0] m,
   output logic [3:0] r,
   output logic       overflow
);

   logic [3:0] sum;
   logic [3:0] diff;
   logic [3:0] r_nxt;
   logic       ov_nxt;

   // Carry/borrow out of bit 3 is intentionally dropped: results wrap mod 16.
   assign sum  = a + b + {3'b000, cin};
   assign diff = a - b - {3'b000, cin};

   always_comb begin
      r_nxt  = 4'b0000;
      ov_nxt = 1'b0;
      case (m)
         4'd0: begin
            r_nxt  = sum;
            ov_nxt = (a[3] == b[3]) && (sum[3] != a[3]);
         end
         4'd1: begin
            r_nxt  = diff;
            ov_nxt = (a[3] != b[3]) && (diff[3] != a[3]);
         end
         4'd2:  r_nxt = {1'b0, (a > b), (a == b), (a < b)};
         4'd3:  r_nxt = a & b;
         4'd4:  r_nxt = a | b;
         4'd5:  r_nxt = a ^ b;
         4'd6:  r_nxt = ~(a | b);
         4'd7:  r_nxt = ~(a ^ b);
         4'd8:  r_nxt = {a[2:0], 1'b0};
         4'd9:  r_nxt = {a[2:0], 1'b1};
         4'd10: r_nxt = {1'b0, a[3:1]};
         4'd11: r_nxt = {1'b1, a[3:1]};
         4'd12: begin
            // Arithmetic left shift overflows when the sign bit changes.
            r_nxt  = {a[2:0], 1'b0};
            ov_nxt = a[3] ^ a[2];
         end
         4'd13: r_nxt = {a[3], a[3:1]};
         4'd14: r_nxt = {a[2:0], a[3]};
         4'd15: r_nxt = {a[0], a[3:1]};
         default: begin
            r_nxt  = 4'b0000;
            ov_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r        <= 4'b0000;
         overflow <= 1'b0;
      end else begin
         r        <= r_nxt;
         overflow <= ov_nxt;
      end
   end

endmodule

// File: tb/tb_alu_4bit.sv
// Directed testbench for alu_4bit: each feature task drives vectors with
// hand-computed expected results and compares inline.
module tb_alu_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] m;
   logic [3:0] r;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] m;
      logic [3:0] er;
      logic       eov;
   } vec_t;

   alu_4bit dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .m        (m),
      .r        (r),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Drive inputs away from the active edge, then sample just after it.
   task automatic cycle(input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input logic [3:0] tm);
      @(negedge clk);
      a   = ta;
      b   = tb;
      cin = tc;
      m   = tm;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a   = 4'd5;
      b   = 4'd5;
      cin = 1'b0;
      m   = 4'd0;
      #2;
      checks++;
      if (r !== 4'b0000 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_pre_clk: got r=%b ov=%b, required r=0000 ov=0", r, overflow);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (r !== 4'b0000 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_held: got r=%b ov=%b, required r=0000 ov=0", r, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_sub;
      vec_t v[9] = '{
         '{4'd2,  4'd1, 1'b0, 4'd0, 4'd3,  1'b0},
         '{4'd5,  4'd2, 1'b0, 4'd0, 4'd7,  1'b0},
         '{4'd10, 4'd2, 1'b0, 4'd0, 4'd12, 1'b0},
         '{4'd5,  4'd5, 1'b0, 4'd0, 4'd10, 1'b1},
         '{4'd7,  4'd0, 1'b1, 4'd0, 4'd8,  1'b1},
         '{4'd15, 4'd1, 1'b0, 4'd0, 4'd0,  1'b0},
         '{4'd14, 4'd2, 1'b0, 4'd1, 4'd12, 1'b0},
         '{4'd8,  4'd1, 1'b0, 4'd1, 4'd7,  1'b1},
         '{4'd0,  4'd0, 1'b1, 4'd1, 4'd15, 1'b0}
      };
      foreach (v[i]) begin
         cycle(v[i].a, v[i].b, v[i].cin, v[i].m);
         checks++;
         if (r !== v[i].er || overflow !== v[i].eov) begin
            failures++;
            $display("FAIL add_sub[%0d] a=%0d b=%0d cin=%0d m=%0d: got r=%0d ov=%b, required r=%0d ov=%b",
                     i, v[i].a, v[i].b, v[i].cin, v[i].m, r, overflow, v[i].er, v[i].eov);
         end
      end
   endtask

   task automatic test_cmp_logic;
      vec_t v[10] = '{
         '{4'd2,  4'd1,  1'b0, 4'd2, 4'b0100, 1'b0},
         '{4'd5,  4'd5,  1'b0, 4'd2, 4'b0010, 1'b0},
         '{4'd1,  4'd3,  1'b0, 4'd2, 4'b0001, 1'b0},
         '{4'd1,  4'd15, 1'b0, 4'd2, 4'b0001, 1'b0},
         '{4'd9,  4'd9,  1'b1, 4'd2, 4'b0010, 1'b0},
         '{4'd14, 4'd2,  1'b0, 4'd3, 4'd2,    1'b0},
         '{4'd14, 4'd2,  1'b0, 4'd4, 4'd14,   1'b0},
         '{4'd14, 4'd2,  1'b0, 4'd5, 4'd12,   1'b0},
         '{4'd14, 4'd2,  1'b0, 4'd6, 4'd1,    1'b0},
         '{4'd14, 4'd2,  1'b0, 4'd7, 4'd3,    1'b0}
      };
      foreach (v[i]) begin
         cycle(v[i].a, v[i].b, v[i].cin, v[i].m);
         checks++;
         if (r !== v[i].er || overflow !== v[i].eov) begin
            failures++;
            $display("FAIL cmp_logic[%0d] a=%0d b=%0d m=%0d: got r=%b ov=%b, required r=%b ov=%b",
                     i, v[i].a, v[i].b, v[i].m, r, overflow, v[i].er, v[i].eov);
         end
      end
   endtask

   task automatic test_shift;
      vec_t v[9] = '{
         '{4'b1001, 4'hf, 1'b1, 4'd8,  4'b0010, 1'b0},
         '{4'b1001, 4'hf, 1'b1, 4'd9,  4'b0011, 1'b0},
         '{4'b1001, 4'hf, 1'b1, 4'd10, 4'b0100, 1'b0},
         '{4'b1001, 4'hf, 1'b1, 4'd11, 4'b1100, 1'b0},
         '{4'b1001, 4'hf, 1'b1, 4'd13, 4'b1100, 1'b0},
         '{4'b0110, 4'h0, 1'b0, 4'd13, 4'b0011, 1'b0},
         '{4'b1001, 4'h0, 1'b0, 4'd12, 4'b0010, 1'b1},
         '{4'b0011, 4'h0, 1'b0, 4'd12, 4'b0110, 1'b0},
         '{4'b0100, 4'h0, 1'b0, 4'd12, 4'b1000, 1'b1}
      };
      foreach (v[i]) begin
         cycle(v[i].a, v[i].b, v[i].cin, v[i].m);
         checks++;
         if (r !== v[i].er || overflow !== v[i].eov) begin
            failures++;
            $display("FAIL shift[%0d] a=%b m=%0d: got r=%b ov=%b, required r=%b ov=%b",
                     i, v[i].a, v[i].m, r, overflow, v[i].er, v[i].eov);
         end
      end
   endtask

   task automatic test_rotate;
      vec_t v[4] = '{
         '{4'b1001, 4'h5, 1'b1, 4'd14, 4'b0011, 1'b0},
         '{4'b1001, 4'h5, 1'b1, 4'd15, 4'b1100, 1'b0},
         '{4'b1000, 4'h0, 1'b0, 4'd15, 4'b0100, 1'b0},
         '{4'b1110, 4'h0, 1'b0, 4'd14, 4'b1101, 1'b0}
      };
      foreach (v[i]) begin
         cycle(v[i].a, v[i].b, v[i].cin, v[i].m);
         checks++;
         if (r !== v[i].er || overflow !== v[i].eov) begin
            failures++;
            $display("FAIL rotate[%0d] a=%b m=%0d: got r=%b ov=%b, required r=%b ov=%b",
                     i, v[i].a, v[i].m, r, overflow, v[i].er, v[i].eov);
         end
      end
   endtask

   task automatic test_back_to_back;
      vec_t v[5] = '{
         '{4'd3, 4'd5, 1'b0, 4'd4,  4'd7,  1'b0},
         '{4'd6, 4'd6, 1'b0, 4'd0,  4'd12, 1'b1},
         '{4'd6, 4'd6, 1'b0, 4'd2,  4'd2,  1'b0},
         '{4'd6, 4'd6, 1'b0, 4'd14, 4'd12, 1'b0},
         '{4'd6, 4'd6, 1'b1, 4'd1,  4'd15, 1'b0}
      };
      foreach (v[i]) begin
         cycle(v[i].a, v[i].b, v[i].cin, v[i].m);
         checks++;
         if (r !== v[i].er || overflow !== v[i].eov) begin
            failures++;
            $display("FAIL back_to_back[%0d] m=%0d: got r=%0d ov=%b, required r=%0d ov=%b",
                     i, v[i].m, r, overflow, v[i].er, v[i].eov);
         end
      end
      // Last result was 15; inputs changing between edges must not leak through.
      a   = 4'd0;
      b   = 4'd0;
      cin = 1'b0;
      m   = 4'd0;
      #2;
      checks++;
      if (r !== 4'd15 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL hold_between_edges: got r=%0d ov=%b, required r=15 ov=0", r, overflow);
      end
   endtask

   task automatic test_mid_reset;
      cycle(4'd5, 4'd5, 1'b0, 4'd0);
      checks++;
      if (r !== 4'd10 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got r=%0d ov=%b, required r=10 ov=1", r, overflow);
      end
      @(negedge clk);
      a   = 4'd1;
      b   = 4'd1;
      cin = 1'b0;
      m   = 4'd0;
      rst = 1'b1;
      #1;
      checks++;
      if (r !== 4'd0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_async: got r=%0d ov=%b, required r=0 ov=0", r, overflow);
      end
      @(posedge clk);
      #1;
      checks++;
      if (r !== 4'd0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_held: got r=%0d ov=%b, required r=0 ov=0", r, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (r !== 4'd2 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_load: got r=%0d ov=%b, required r=2 ov=0", r, overflow);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_cmp_logic();
      test_shift();
      test_rotate();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
